md_unit: RTL and testbench

Multiply/divide unit with HI/LO registers, added alongside the ALU when the CPU moves from the single-cycle datapath to the pipelined one. It takes both GRF read operands from the execute stage, runs `mult`/`multu`/`div`/`divu` as fixed-latency multi-cycle operations, and services `mthi`/`mtlo` writes and `mfhi`/`mflo` reads. It raises `busy` and `stall_req` so hazard logic can hold the pipeline until results are committed.

---
 rtl/md_unit.sv | 112 +++++++++++
 tb/tb_md_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the pipelined datapath.
// Runs mult/multu/div/divu as fixed-latency operations and services mthi/mtlo.
// The result is computed at issue into a shadow pair. It is committed to
// HI/LO only when the countdown expires, so hi/lo never show partial values.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] res_hi, res_lo;
  logic        res_vld;  // cleared for divide-by-zero: commit leaves HI/LO alone

  logic        is_md, sgn;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
  logic [31:0] nxt_hi, nxt_lo;
  logic        nxt_vld;

  assign is_md     = ~md_op[2];  // ops 0..3
  assign sgn       = ~md_op[0];  // mult and div are the signed variants
  assign busy      = (state == S_RUN);
  assign stall_req = reset & (busy | (start & is_md));

  // Result of the op presented this cycle.
  // Division works on magnitudes, then fixes the signs: the quotient truncates
  // toward zero and the remainder follows the dividend. 0x80000000 / -1 falls
  // out naturally as quotient 0x80000000, remainder 0.
  always_comb begin
    prod    = '0;
    a_mag   = (sgn && a[31]) ? (~a + 32'd1) : a;
    b_mag   = (sgn && b[31]) ? (~b + 32'd1) : b;
    b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = '0;
    r_mag   = '0;
    nxt_hi  = '0;
    nxt_lo  = '0;
    nxt_vld = 1'b1;
    if (!md_op[1]) begin
      if (sgn) prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else     prod = {32'd0, a} * {32'd0, b};
      nxt_hi = prod[63:32];
      nxt_lo = prod[31:0];
    end else begin
      q_mag   = a_mag / b_safe;
      r_mag   = a_mag % b_safe;
      nxt_lo  = (sgn && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
      nxt_hi  = (sgn && a[31]) ? (~r_mag + 32'd1) : r_mag;
      nxt_vld = (b != 32'd0);
    end
  end

  // Issue, countdown and commit. Any start in RUN is dropped, not queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      res_hi  <= '0;
      res_lo  <= '0;
      res_vld <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && is_md) begin
            res_hi  <= nxt_hi;
            res_lo  <= nxt_lo;
            res_vld <= nxt_vld;
            cnt     <= md_op[1] ? DIV_N : MULT_N;
            state   <= S_RUN;
          end else if (start && md_op == 3'd4) begin
            hi <= a;
          end else if (start && md_op == 3'd5) begin
            lo <= a;
          end
        end
        default: begin
          if (cnt == 4'd1) begin
            if (res_vld) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit. It drives inputs 1 time unit after each rising
// edge and checks outputs before the next edge.
module tb_md_unit;
  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int n;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .a(a), .b(b), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one start for a single cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; md_op = op; a = av; b = bv;
    step();
    start = 1'b0; md_op = 3'd7;
  endtask

  // Count busy cycles until idle. The wait is bounded to 40 cycles.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      step();
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; md_op = 3'd0; a = 32'd5; b = 32'd6;
    #12;
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_hi",    hi, 32'd0);
    check("rst_lo",    lo, 32'd0);
    start = 1'b0; md_op = 3'd7;
    step();
    reset = 1'b1;
    step();

    // mult -1 * 2
    start = 1'b1; md_op = 3'd0; a = 32'hFFFF_FFFF; b = 32'd2;
    #1;
    check("mult_issue_stall", {31'd0, stall_req}, 32'd1);
    check("mult_issue_busy",  {31'd0, busy}, 32'd0);
    step();
    start = 1'b0; md_op = 3'd7;
    check("mult_busy_hold_lo", lo, 32'd0);
    wait_idle(n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);

    // multu 0xFFFFFFFF * 2, issued back-to-back in the first idle cycle
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_cycles", n, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // div overflow case
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0000_0000);

    // divu 100 / 7
    issue(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // mthi, then divu by zero leaves HI/LO alone
    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_hi",   hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_lo",   lo, 32'd14);
    issue(3'd3, 32'd7, 32'd0);
    wait_idle(n);
    check("divz_cycles", n, 32'd10);
    check("divz_hi", hi, 32'h1234_5678);
    check("divz_lo", lo, 32'd14);

    // mtlo
    issue(3'd5, 32'h0000_A5A5, 32'd0);
    check("mtlo_lo", lo, 32'h0000_A5A5);

    // op 6 has no effect
    issue(3'd6, 32'h5555_5555, 32'h1);
    check("nop_hi", hi, 32'h1234_5678);
    check("nop_lo", lo, 32'h0000_A5A5);
    check("nop_busy", {31'd0, busy}, 32'd0);

    // mult 3*4; mtlo in busy cycle 2 is ignored; operand change in cycle 3 is ignored
    issue(3'd0, 32'd3, 32'd4);       // now in busy cycle 1
    step();                          // busy cycle 2
    check("ign_busy2", {31'd0, busy}, 32'd1);
    issue(3'd5, 32'h0000_DEAD, 32'd0); // now in busy cycle 3
    check("ign_lo", lo, 32'h0000_A5A5);
    a = 32'd9; b = 32'd9;
    wait_idle(n);
    check("ign_cycles", n, 32'd3);
    check("ign_hi", hi, 32'd0);
    check("ign_lo_final", lo, 32'h0000_000C);

    // reset mid-divide aborts it
    issue(3'd2, 32'd100, 32'd7);     // busy cycle 1
    step(); step(); step();          // busy cycle 4
    #2;
    reset = 1'b0;
    start = 1'b1; md_op = 3'd2;
    #1;
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_hi",    hi, 32'd0);
    check("abort_lo",    lo, 32'd0);
    check("abort_stall", {31'd0, stall_req}, 32'd0);
    start = 1'b0; md_op = 3'd7;
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_hi",   hi, 32'd0);
    check("post_lo",   lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
